// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter letting two request ways share one RAM port.
// One access at a time: grant in IDLE, hold the registered request in READ/WRITE until the RAM completes.
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              way0_valid_i,
   input  logic [ADDR_W-1:0] way0_readAddr_i,
   input  logic [ADDR_W-1:0] way0_writeAddr_i,
   input  logic [DATA_W-1:0] way0_writeData_i,
   input  logic [3:0]        way0_writeMask_i,
   input  logic              way1_valid_i,
   input  logic [ADDR_W-1:0] way1_readAddr_i,
   input  logic [ADDR_W-1:0] way1_writeAddr_i,
   input  logic [DATA_W-1:0] way1_writeData_i,
   input  logic [3:0]        way1_writeMask_i,
   input  logic              dataOk_i,
   input  logic [DATA_W-1:0] readData_i,
   input  logic [2:0]        writeState_i,
   output logic [ADDR_W-1:0] readAddr_o,
   output logic [ADDR_W-1:0] writeAddr_o,
   output logic [DATA_W-1:0] writeData_o,
   output logic [3:0]        writeMask_o,
   output logic              way0_ready_o,
   output logic              way1_ready_o,
   output logic              respValid_o,
   output logic              respWay_o,
   output logic [DATA_W-1:0] respData_o
);
   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
   state_t            state_q, state_d;
   logic              last_q, last_d, way_q, way_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d, waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        wmask_q, wmask_d;
   logic              req0, req1, gnt, resp_valid, done;
   logic [ADDR_W-1:0] sel_raddr, sel_waddr;
   logic [DATA_W-1:0] sel_wdata;
   logic [3:0]        sel_wmask;

   assign req0 = way0_valid_i & (|way0_readAddr_i | |way0_writeAddr_i);
   assign req1 = way1_valid_i & (|way1_readAddr_i | |way1_writeAddr_i);
   // on a tie the way that did not win last time is served
   assign gnt = (req0 & req1) ? ~last_q : req1;
   assign sel_raddr = gnt ? way1_readAddr_i : way0_readAddr_i;
   assign sel_waddr = gnt ? way1_writeAddr_i : way0_writeAddr_i;
   assign sel_wdata = gnt ? way1_writeData_i : way0_writeData_i;
   assign sel_wmask = gnt ? way1_writeMask_i : way0_writeMask_i;
   assign resp_valid = (state_q == READ) & dataOk_i;
   assign done = resp_valid | ((state_q == WRITE) & (writeState_i == 3'b111));

   always_comb begin
      state_d = state_q;
      last_d = last_q;
      way_d = way_q;
      raddr_d = raddr_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      case (state_q)
         IDLE: if (req0 | req1) begin
            way_d = gnt;
            last_d = gnt;
            if (|sel_raddr) begin
               state_d = READ;
               raddr_d = sel_raddr;
            end else begin
               state_d = WRITE;
               waddr_d = sel_waddr;
               wdata_d = sel_wdata;
               wmask_d = sel_wmask;
            end
         end
         READ, WRITE: state_d = done ? IDLE : state_q;
         default: state_d = IDLE;
      endcase
      // RAM request lines are quiet whenever the next state is IDLE
      if (state_d == IDLE) begin
         raddr_d = '0;
         waddr_d = '0;
         wdata_d = '0;
         wmask_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         last_q <= 1'b1;
         way_q <= 1'b0;
         raddr_q <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
      end else begin
         state_q <= state_d;
         last_q <= last_d;
         way_q <= way_d;
         raddr_q <= raddr_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
      end
   end

   assign readAddr_o = raddr_q;
   assign writeAddr_o = waddr_q;
   assign writeData_o = wdata_q;
   assign writeMask_o = wmask_q;
   assign way0_ready_o = ~req0 | (done & ~way_q);
   assign way1_ready_o = ~req1 | (done & way_q);
   assign respValid_o = resp_valid;
   assign respWay_o = resp_valid & way_q;
   assign respData_o = resp_valid ? readData_i : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_port_arbiter;
   localparam int AW = 32;
   localparam int DW = 64;
   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          way0_valid_i, way1_valid_i, dataOk_i;
   logic [AW-1:0] way0_readAddr_i, way0_writeAddr_i, way1_readAddr_i, way1_writeAddr_i;
   logic [DW-1:0] way0_writeData_i, way1_writeData_i, readData_i;
   logic [3:0]    way0_writeMask_i, way1_writeMask_i;
   logic [2:0]    writeState_i;
   logic [AW-1:0] readAddr_o, writeAddr_o;
   logic [DW-1:0] writeData_o, respData_o;
   logic [3:0]    writeMask_o;
   logic          way0_ready_o, way1_ready_o, respValid_o, respWay_o;
   int            errors = 0;
   int            checks = 0;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset_n(reset_n),
      .way0_valid_i(way0_valid_i), .way0_readAddr_i(way0_readAddr_i), .way0_writeAddr_i(way0_writeAddr_i),
      .way0_writeData_i(way0_writeData_i), .way0_writeMask_i(way0_writeMask_i),
      .way1_valid_i(way1_valid_i), .way1_readAddr_i(way1_readAddr_i), .way1_writeAddr_i(way1_writeAddr_i),
      .way1_writeData_i(way1_writeData_i), .way1_writeMask_i(way1_writeMask_i),
      .dataOk_i(dataOk_i), .readData_i(readData_i), .writeState_i(writeState_i),
      .readAddr_o(readAddr_o), .writeAddr_o(writeAddr_o), .writeData_o(writeData_o), .writeMask_o(writeMask_o),
      .way0_ready_o(way0_ready_o), .way1_ready_o(way1_ready_o),
      .respValid_o(respValid_o), .respWay_o(respWay_o), .respData_o(respData_o)
   );

   always #5 clk = ~clk;

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      way0_valid_i = 0; way0_readAddr_i = '0; way0_writeAddr_i = '0; way0_writeData_i = '0; way0_writeMask_i = '0;
      way1_valid_i = 0; way1_readAddr_i = '0; way1_writeAddr_i = '0; way1_writeData_i = '0; way1_writeMask_i = '0;
      dataOk_i = 0; readData_i = '0; writeState_i = '0;
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      #1 reset_n = 1'b0;
      smp();
      checks++;
      if ({readAddr_o, writeAddr_o, writeData_o, writeMask_o, respValid_o, respWay_o, respData_o} !== '0) begin
         errors++; $display("FAIL reset_outputs: got ra=%h wa=%h rv=%b rd=%h want all zero", readAddr_o, writeAddr_o, respValid_o, respData_o);
      end
      checks++;
      if ({way0_ready_o, way1_ready_o} !== 2'b11) begin
         errors++; $display("FAIL reset_ready_idle: got %b%b want 11", way0_ready_o, way1_ready_o);
      end
      way0_valid_i = 1; way0_readAddr_i = 32'h5; way1_valid_i = 1; way1_writeAddr_i = 32'h9;
      smp();
      checks++;
      if ({way0_ready_o, way1_ready_o, readAddr_o, writeAddr_o} !== {2'b00, 64'h0}) begin
         errors++; $display("FAIL reset_ready_req: got rdy=%b%b ra=%h wa=%h want 00 0 0", way0_ready_o, way1_ready_o, readAddr_o, writeAddr_o);
      end
      idle_inputs();
      nxt();
      reset_n = 1'b1;
   endtask

   task automatic test_load();
      nxt();
      way0_valid_i = 1; way0_readAddr_i = 32'h100;
      smp();
      checks++;
      if ({way0_ready_o, readAddr_o, respValid_o} !== {1'b0, 32'h0, 1'b0}) begin
         errors++; $display("FAIL load_grant: got rdy=%b ra=%h rv=%b want 0 0 0", way0_ready_o, readAddr_o, respValid_o);
      end
      nxt();
      writeState_i = 3'b111;
      smp();
      checks++;
      if ({readAddr_o, writeAddr_o, way0_ready_o, respValid_o} !== {32'h100, 32'h0, 2'b00}) begin
         errors++; $display("FAIL load_accept: got ra=%h wa=%h rdy=%b rv=%b want 100 0 0 0", readAddr_o, writeAddr_o, way0_ready_o, respValid_o);
      end
      nxt();
      writeState_i = 3'b000; dataOk_i = 1; readData_i = 64'hDEAD;
      smp();
      checks++;
      if ({respValid_o, respWay_o, respData_o, way0_ready_o, readAddr_o} !== {2'b10, 64'hDEAD, 1'b1, 32'h100}) begin
         errors++; $display("FAIL load_resp: got rv=%b rw=%b rd=%h rdy=%b ra=%h want 1 0 dead 1 100", respValid_o, respWay_o, respData_o, way0_ready_o, readAddr_o);
      end
      nxt();
      way0_valid_i = 0; way0_readAddr_i = '0;
      smp();
      checks++;
      if ({respValid_o, respData_o, readAddr_o, way0_ready_o} !== {1'b0, 64'h0, 32'h0, 1'b1}) begin
         errors++; $display("FAIL load_after: got rv=%b rd=%h ra=%h rdy=%b want 0 0 0 1", respValid_o, respData_o, readAddr_o, way0_ready_o);
      end
      nxt();
      idle_inputs();
   endtask

   task automatic test_simultaneous();
      pulse_reset();
      way0_valid_i = 1; way0_readAddr_i = 32'h10;
      way1_valid_i = 1; way1_writeAddr_i = 32'h20; way1_writeData_i = 64'h55; way1_writeMask_i = 4'hF;
      smp();
      checks++;
      if ({way0_ready_o, way1_ready_o} !== 2'b00) begin
         errors++; $display("FAIL sim_grant_ready: got %b%b want 00", way0_ready_o, way1_ready_o);
      end
      nxt();
      smp();
      checks++;
      if ({readAddr_o, writeAddr_o} !== {32'h10, 32'h0}) begin
         errors++; $display("FAIL sim_first: got ra=%h wa=%h want 10 0", readAddr_o, writeAddr_o);
      end
      nxt();
      dataOk_i = 1; readData_i = 64'h77;
      smp();
      checks++;
      if ({respValid_o, respWay_o, way0_ready_o, way1_ready_o, respData_o} !== {4'b1010, 64'h77}) begin
         errors++; $display("FAIL sim_resp0: got rv=%b rw=%b rdy=%b%b rd=%h want 1 0 10 77", respValid_o, respWay_o, way0_ready_o, way1_ready_o, respData_o);
      end
      nxt();
      way0_valid_i = 0; way0_readAddr_i = '0; dataOk_i = 0;
      smp();
      checks++;
      if ({readAddr_o, writeAddr_o, way1_ready_o} !== 65'h0) begin
         errors++; $display("FAIL sim_idle_gap: got ra=%h wa=%h rdy1=%b want 0 0 0", readAddr_o, writeAddr_o, way1_ready_o);
      end
      nxt();
      writeState_i = 3'b001; dataOk_i = 1;
      smp();
      checks++;
      if ({writeAddr_o, writeData_o, writeMask_o, readAddr_o, respValid_o, way1_ready_o} !== {32'h20, 64'h55, 4'hF, 32'h0, 2'b00}) begin
         errors++; $display("FAIL sim_write: got wa=%h wd=%h wm=%h ra=%h rv=%b rdy1=%b want 20 55 f 0 0 0", writeAddr_o, writeData_o, writeMask_o, readAddr_o, respValid_o, way1_ready_o);
      end
      nxt();
      writeState_i = 3'b011; dataOk_i = 0;
      smp();
      checks++;
      if ({writeAddr_o, way1_ready_o} !== {32'h20, 1'b0}) begin
         errors++; $display("FAIL sim_write_wait: got wa=%h rdy1=%b want 20 0", writeAddr_o, way1_ready_o);
      end
      nxt();
      writeState_i = 3'b111;
      smp();
      checks++;
      if ({way1_ready_o, respValid_o, writeMask_o} !== {2'b10, 4'hF}) begin
         errors++; $display("FAIL sim_write_done: got rdy1=%b rv=%b wm=%h want 1 0 f", way1_ready_o, respValid_o, writeMask_o);
      end
      nxt();
      way1_valid_i = 0; way1_writeAddr_i = '0;
      smp();
      checks++;
      if ({writeAddr_o, writeMask_o, way0_ready_o, way1_ready_o} !== {36'h0, 2'b11}) begin
         errors++; $display("FAIL sim_after: got wa=%h wm=%h rdy=%b%b want 0 0 11", writeAddr_o, writeMask_o, way0_ready_o, way1_ready_o);
      end
      nxt();
      idle_inputs();
   endtask

   task automatic test_round_robin();
      pulse_reset();
      way0_valid_i = 1; way0_readAddr_i = 32'h40;
      way1_valid_i = 1; way1_readAddr_i = 32'h80;
      for (int k = 0; k < 4; k++) begin
         automatic logic e = 1'(k & 1);
         nxt();
         smp();
         checks++;
         if (readAddr_o !== (e ? 32'h80 : 32'h40)) begin
            errors++; $display("FAIL rr_grant%0d: got ra=%h want way %0d", k, readAddr_o, e);
         end
         nxt();
         dataOk_i = 1;
         smp();
         checks++;
         if ({respValid_o, respWay_o, way0_ready_o, way1_ready_o} !== {1'b1, e, ~e, e}) begin
            errors++; $display("FAIL rr_resp%0d: got rv=%b rw=%b rdy=%b%b want 1 %b %b%b", k, respValid_o, respWay_o, way0_ready_o, way1_ready_o, e, ~e, e);
         end
         nxt();
         dataOk_i = 0;
      end
      idle_inputs();
      nxt();
   endtask

   task automatic test_valid_drop();
      way1_valid_i = 1; way1_readAddr_i = 32'h60;
      nxt();
      way1_valid_i = 0;
      smp();
      checks++;
      if ({readAddr_o, way1_ready_o} !== {32'h60, 1'b1}) begin
         errors++; $display("FAIL drop_hold: got ra=%h rdy1=%b want 60 1", readAddr_o, way1_ready_o);
      end
      nxt();
      dataOk_i = 1; readData_i = 64'h1234;
      smp();
      checks++;
      if ({respValid_o, respWay_o, respData_o} !== {2'b11, 64'h1234}) begin
         errors++; $display("FAIL drop_resp: got rv=%b rw=%b rd=%h want 1 1 1234", respValid_o, respWay_o, respData_o);
      end
      nxt();
      idle_inputs();
      nxt();
   endtask

   task automatic test_reset_mid();
      way0_valid_i = 1; way0_readAddr_i = 32'h300;
      nxt();
      smp();
      checks++;
      if (readAddr_o !== 32'h300) begin
         errors++; $display("FAIL rmid_before: got ra=%h want 300", readAddr_o);
      end
      #2;
      dataOk_i = 1;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({readAddr_o, respValid_o, respData_o, way0_ready_o} !== {97'h0, 1'b0}) begin
         errors++; $display("FAIL rmid_async: got ra=%h rv=%b rd=%h rdy0=%b want 0 0 0 0", readAddr_o, respValid_o, respData_o, way0_ready_o);
      end
      nxt();
      way0_valid_i = 0; way0_readAddr_i = '0;
      reset_n = 1'b1;
      smp();
      checks++;
      if ({respValid_o, readAddr_o, way0_ready_o} !== {33'h0, 1'b1}) begin
         errors++; $display("FAIL rmid_stale: got rv=%b ra=%h rdy0=%b want 0 0 1", respValid_o, readAddr_o, way0_ready_o);
      end
      nxt();
      dataOk_i = 0;
      way0_valid_i = 1; way0_readAddr_i = 32'h11; way1_valid_i = 1; way1_readAddr_i = 32'h22;
      nxt();
      smp();
      checks++;
      if (readAddr_o !== 32'h11) begin
         errors++; $display("FAIL rmid_tie: got ra=%h want 11", readAddr_o);
      end
      nxt();
      dataOk_i = 1;
      nxt();
      idle_inputs();
      nxt();
   endtask

   task automatic test_random();
      logic          hv[2];
      logic [AW-1:0] ra[2], wa[2];
      logic [DW-1:0] wd[2];
      logic [3:0]    wm[2];
      logic          act, mw, ml, mlast, cmp, rv;
      logic [AW-1:0] mra, mwa, era, ewa;
      logic [DW-1:0] mwd, ewd, erd;
      logic [3:0]    mwm, ewm;
      logic [1:0]    rdy;
      hv[0] = 0; hv[1] = 0; act = 0; mlast = 1; mw = 0; ml = 0;
      mra = '0; mwa = '0; mwd = '0; mwm = '0;
      pulse_reset();
      for (int n = 0; n < 3000; n++) begin
         for (int w = 0; w < 2; w++) begin
            if (!hv[w] && $urandom_range(0, 1) == 1) begin
               hv[w] = 1;
               ra[w] = $urandom_range(0, 1) == 1 ? 32'($urandom_range(1, 65535)) : 32'h0;
               wa[w] = (ra[w] == 0 || $urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 65535)) : 32'h0;
               wd[w] = {$urandom, $urandom};
               wm[w] = 4'($urandom);
            end else if (!hv[w]) begin
               ra[w] = $urandom; wa[w] = $urandom; wd[w] = {$urandom, $urandom}; wm[w] = 4'($urandom);
            end
         end
         way0_valid_i = hv[0]; way0_readAddr_i = ra[0]; way0_writeAddr_i = wa[0]; way0_writeData_i = wd[0]; way0_writeMask_i = wm[0];
         way1_valid_i = hv[1]; way1_readAddr_i = ra[1]; way1_writeAddr_i = wa[1]; way1_writeData_i = wd[1]; way1_writeMask_i = wm[1];
         dataOk_i = $urandom_range(0, 2) == 0;
         readData_i = {$urandom, $urandom};
         writeState_i = $urandom_range(0, 2) == 0 ? 3'b111 : 3'($urandom_range(0, 6));
         smp();
         cmp = act && (ml ? dataOk_i : writeState_i == 3'b111);
         rv = act && ml && dataOk_i;
         rdy = {!hv[1] || (cmp && mw), !hv[0] || (cmp && !mw)};
         era = (act && ml) ? mra : '0;
         ewa = (act && !ml) ? mwa : '0;
         ewd = (act && !ml) ? mwd : '0;
         ewm = (act && !ml) ? mwm : '0;
         erd = rv ? readData_i : '0;
         checks++;
         if ({readAddr_o, writeAddr_o, writeData_o, writeMask_o} !== {era, ewa, ewd, ewm}) begin
            errors++; $display("FAIL rnd_ram c%0d: got ra=%h wa=%h wd=%h wm=%h want %h %h %h %h", n, readAddr_o, writeAddr_o, writeData_o, writeMask_o, era, ewa, ewd, ewm);
         end
         checks++;
         if ({respValid_o, respWay_o, respData_o} !== {rv, rv && mw, erd}) begin
            errors++; $display("FAIL rnd_resp c%0d: got rv=%b rw=%b rd=%h want %b %b %h", n, respValid_o, respWay_o, respData_o, rv, rv && mw, erd);
         end
         checks++;
         if ({way1_ready_o, way0_ready_o} !== rdy) begin
            errors++; $display("FAIL rnd_ready c%0d: got %b%b want %b", n, way1_ready_o, way0_ready_o, rdy);
         end
         if (cmp) act = 0;
         else if (!act && (hv[0] || hv[1])) begin
            mw = (hv[0] && hv[1]) ? !mlast : hv[1];
            mlast = mw;
            ml = |ra[mw];
            mra = ra[mw]; mwa = wa[mw]; mwd = wd[mw]; mwm = wm[mw];
            act = 1;
         end
         for (int w = 0; w < 2; w++) if (hv[w] && rdy[w]) hv[w] = 0;
         nxt();
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_load();
      test_simultaneous();
      test_round_robin();
      test_valid_drop();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
